mdu_ctrl: RTL

// - Multi-cycle multiply/divide sequencer with HI/LO registers for the pipelined MIPS core.
// - Sits beside the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
// - Raises busy so the hazard unit stalls later MDU instructions, including MFHI/MFLO.
// - Commits results to HI/LO after a fixed latency.

---
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers for the MIPS EX stage.
// Build option MDU_DIV0_GUARD_EN: divide by zero leaves HI/LO untouched instead of committing {A, all-ones}.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write HI/LO directly
// RUN   | counting down on latched operands; commit on terminal count
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [2:0]         op_q;
    logic [31:0]        a_q, b_q;
    logic [31:0]        hi_nxt, lo_nxt;
    logic               latch;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               sdiv;
    logic [31:0]        dv_a, dv_b, uq, ur, quo, rem;

    // Signed divide works on magnitudes so the 0x80000000 / -1 case wraps cleanly.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        sdiv   = (op_q == OP_DIV);
        dv_a   = (sdiv && a_q[31]) ? (32'd0 - a_q) : a_q;
        dv_b   = (sdiv && b_q[31]) ? (32'd0 - b_q) : b_q;
        uq     = dv_a / dv_b;
        ur     = dv_a % dv_b;
        quo    = (sdiv && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
        rem    = (sdiv && a_q[31]) ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            latch     = 1'b1;
                            cnt_nxt   = MULT_LOAD;
                            state_nxt = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            latch     = 1'b1;
                            cnt_nxt   = DIV_LOAD;
                            state_nxt = RUN;
                        end
                        OP_MTHI: hi_nxt = rs_data;
                        OP_MTLO: lo_nxt = rs_data;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
                        OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
                        default: begin
                            if (b_q == 32'd0) begin
`ifdef MDU_DIV0_GUARD_EN
                                hi_nxt = hi;
                                lo_nxt = lo;
`else
                                hi_nxt = a_q;
                                lo_nxt = 32'hFFFF_FFFF;
`endif
                            end else begin
                                hi_nxt = rem;
                                lo_nxt = quo;
                            end
                        end
                    endcase
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            if (latch) begin
                op_q <= op;
                a_q  <= rs_data;
                b_q  <= rt_data;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
